// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline hazard and stall sequencer for the 5-stage core.
// Detects load-use hazards that forwarding cannot cover, freezes the front of
// the pipe while a multi-cycle op occupies EXE, flushes on taken branches and
// holds everything during data-memory wait states.
// Optional build macro: HZ_PERF_CNT_EN adds saturating stall/flush counters on
// PERF_STALL / PERF_FLUSH; without it both ports are tied to zero.
module hazard_stall_ctrl #(
  parameter int REG_W  = 4,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [REG_W-1:0] ID_OP1,
  input  logic [REG_W-1:0] ID_OP2,
  input  logic             ID_USES_OP2,
  input  logic [REG_W-1:0] ID_EXE_OP1,
  input  logic             ID_EXE_WB,
  input  logic             ID_EXE_MEMRD,
  input  logic             EXE_MC_START,
  input  logic             BR_TAKEN,
  input  logic             DMEM_BUSY,
  output logic             PC_EN,
  output logic             IF_ID_EN,
  output logic             ID_EXE_EN,
  output logic             EXE_MEM_EN,
  output logic             IF_ID_FLUSH,
  output logic             ID_EXE_FLUSH,
  output logic             EXE_MEM_FLUSH,
  output logic             MEM_WB_FLUSH,
  output logic             MC_BUSY,
  output logic [CNT_W-1:0] PERF_STALL,
  output logic [CNT_W-1:0] PERF_FLUSH
);

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } state_t;

  // Counter preload: the start cycle and the final mc_cnt==1 cycle are both
  // freeze cycles, so MC_LAT-2 in the counter yields MC_LAT-1 freezes total.
  localparam logic [3:0] MC_LOAD  = 4'(MC_LAT - 2);
  localparam bit         MC_MULTI = (MC_LAT > 2);

  state_t     state;
  state_t     state_next;
  logic [3:0] mc_cnt;
  logic [3:0] mc_cnt_next;

  logic       op1_match;
  logic       op2_match;
  logic       lu;
  logic       mc_active;

  // Load-use detection: no register is treated specially, R0 included.
  always_comb begin
    op1_match = (ID_EXE_OP1 == ID_OP1);
    op2_match = ID_USES_OP2 && (ID_EXE_OP1 == ID_OP2);
    lu        = ID_EXE_MEMRD && ID_EXE_WB && (op1_match || op2_match);
    mc_active = (state == MC_WAIT) || ((state == RUN) && EXE_MC_START);
  end

  // State register; reset aborts any multi-cycle sequence in progress.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state  <= RUN;
      mc_cnt <= 4'd0;
    end else begin
      state  <= state_next;
      mc_cnt <= mc_cnt_next;
    end
  end

  // Next-state and pipeline controls, resolved in fixed priority order.
  always_comb begin
    state_next    = state;
    mc_cnt_next   = mc_cnt;
    PC_EN         = 1'b1;
    IF_ID_EN      = 1'b1;
    ID_EXE_EN     = 1'b1;
    EXE_MEM_EN    = 1'b1;
    IF_ID_FLUSH   = 1'b0;
    ID_EXE_FLUSH  = 1'b0;
    EXE_MEM_FLUSH = 1'b0;
    MEM_WB_FLUSH  = 1'b0;
    MC_BUSY       = 1'b0;

    if (DMEM_BUSY) begin
      // Memory wait: whole pipe holds, MEM/WB gets a bubble, sequencer frozen.
      PC_EN        = 1'b0;
      IF_ID_EN     = 1'b0;
      ID_EXE_EN    = 1'b0;
      EXE_MEM_EN   = 1'b0;
      MEM_WB_FLUSH = 1'b1;
    end else if (mc_active) begin
      // EXE holds the multi-cycle op; bubbles drain into MEM behind it.
      PC_EN         = 1'b0;
      IF_ID_EN      = 1'b0;
      ID_EXE_EN     = 1'b0;
      EXE_MEM_FLUSH = 1'b1;
      MC_BUSY       = 1'b1;
      if (state == RUN) begin
        if (MC_MULTI) begin
          state_next  = MC_WAIT;
          mc_cnt_next = MC_LOAD;
        end
      end else begin
        mc_cnt_next = mc_cnt - 4'd1;
        if (mc_cnt == 4'd1) begin
          state_next = RUN;
        end
      end
    end else if (BR_TAKEN) begin
      // Squash the two younger instructions fetched down the wrong path.
      IF_ID_FLUSH  = 1'b1;
      ID_EXE_FLUSH = 1'b1;
    end else if (lu) begin
      // One bubble; next cycle the load sits in MEM and forwarding covers it.
      PC_EN        = 1'b0;
      IF_ID_EN     = 1'b0;
      ID_EXE_FLUSH = 1'b1;
    end
  end

`ifdef HZ_PERF_CNT_EN
  logic             br_apply;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // A branch flush counts only when nothing of higher priority overrides it.
  always_comb begin
    br_apply = !DMEM_BUSY && !mc_active && BR_TAKEN;
  end

  // Saturating performance counters, cleared by reset.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!PC_EN && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (br_apply && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  assign PERF_STALL = stall_cnt;
  assign PERF_FLUSH = flush_cnt;
`else
  assign PERF_STALL = '0;
  assign PERF_FLUSH = '0;
`endif

endmodule
